msdap_main_ctrl: RTL and testbench
==================================

# msdap_main_ctrl

Main sequencing controller for the MSDAP datapath, in the SCLK domain. It walks the chip through its phases: initialise, load Rj, load coefficients, wait for input, run, clear, sleep. It generates the write strobes and addresses for the Rj, coefficient and input-data memories, and issues a compute-start pulse per stored sample. Inputs come from the frame synchroniser (`frame_pulse`), the serial deserializer (`word_valid`, `word_nonzero`), the all-zeros detector (`all_zeros`) and the external clear request.

## Interface
- `RJ_DEPTH`, 16, number of Rj words loaded
- `COEFF_DEPTH`, 512, number of coefficient words loaded
- `DATA_DEPTH`, 256, input-data circular buffer depth (power of two)

- `SCLK` in 1: system clock, rising edge
- `start` in 1: reset, synchronous, active-high
- `frame_pulse` in 1: one-cycle pulse per frame start (already in SCLK domain)
- `word_valid` in 1: one-cycle pulse; deserializer word complete and held stable ≥2 cycles
- `word_nonzero` in 1: qualifies `word_valid`; current word has a nonzero L or R channel
- `all_zeros` in 1: 800 consecutive zero samples seen
- `clear_req` in 1: external clear request, active-high, level
- `state` out 4: current state encoding
- `in_ready` out 1: controller accepting serial input
- `rj_we` out 1, `rj_addr` out $clog2(RJ_DEPTH): Rj memory write port
- `coeff_we` out 1, `coeff_addr` out $clog2(COEFF_DEPTH): coefficient memory write port
- `data_we` out 1, `data_addr` out $clog2(DATA_DEPTH): data memory write port
- `data_zero` out 1: data memory write value is forced to 0 (clear sweep)
- `compute_start` out 1: one-cycle pulse, start filter computation for the newest sample
- `sleep` out 1: controller is in SLEEPING

## Operation
- States and encodings: INIT=0, WAIT_RJ=1, READ_RJ=2, WAIT_COEFF=3, READ_COEFF=4, WAIT_INPUT=5, WORKING=6, CLEARING=7, SLEEPING=8.
- **INIT**: zero-sweep of the data memory.
  - `data_we=1`, `data_zero=1`, `data_addr` 0→DATA_DEPTH-1.
  - Go to WAIT_RJ after the last address.
- **WAIT_RJ**: on `frame_pulse`, go to READ_RJ.
- **READ_RJ**: each `word_valid` writes `rj_addr` = count, then increments count.
  - After write RJ_DEPTH-1, go to WAIT_COEFF.
- **WAIT_COEFF / READ_COEFF**: same scheme as Rj, COEFF_DEPTH words. Then go to WAIT_INPUT.
- **WAIT_INPUT**: on `frame_pulse`, go to WORKING with `data_addr`=0.
- **WORKING**: each `word_valid` writes `data_addr`, then `data_addr` increments modulo DATA_DEPTH (DATA_DEPTH-1 wraps to 0). `compute_start` pulses for each stored sample.
- **CLEARING**: zero-sweep identical to INIT, with `in_ready=0`.
  - After the sweep, stay in CLEARING while `clear_req`=1; then go to WAIT_INPUT with `data_addr`=0.
- **SLEEPING**: `sleep=1`, no writes.
  - `word_valid` && `word_nonzero` → WORKING; that word is written at the current `data_addr`.
- `clear_req`=1 in WORKING or SLEEPING → CLEARING. It is ignored in INIT through READ_COEFF; Rj/coeff loads are never aborted.
- Priority each cycle: `start` > `clear_req` > `all_zeros` > `word_valid`.
- Entering CLEARING mid-sweep is impossible (already there). Re-asserting `clear_req` in WAIT_INPUT is ignored.
- `in_ready`=1 in WAIT_RJ through WORKING and in SLEEPING; 0 in INIT and CLEARING.

## Timing
- All outputs are registered. Every output resets to 0: `state`=INIT, addresses 0, strobes 0, `sleep`=0. INIT starts its sweep on the first cycle after `start` deasserts.
- Write strobe (`rj_we`/`coeff_we`/`data_we`) asserts exactly one cycle after `word_valid`, with the address valid in that same cycle.
- `compute_start` asserts one cycle after `data_we` in WORKING. It never asserts during a sweep or in SLEEPING.
- State changes take effect on the clock edge after the qualifying input. A `word_valid` coincident with the transition into WORKING or CLEARING is not written.
- Each sweep lasts exactly DATA_DEPTH cycles of `data_we`.
- `start` mid-operation aborts any state on the next edge: all outputs are 0 and INIT restarts.

## Configuration
- `MSDAP_CTRL_SLEEP_EN` defined: SLEEPING is present. In WORKING, `all_zeros`=1 moves to SLEEPING on the next edge.
- Not defined: the SLEEPING state and the `all_zeros` path are removed. `sleep` is tied to 0 and WORKING stays in WORKING regardless of `all_zeros`.

## Test plan
- `start` pulse → `data_we` high for 256 cycles with addr 0..255 and `data_zero`=1, then `state`=1 and `in_ready`=1.
- `frame_pulse` then 16 `word_valid` → `rj_we` pulses with addr 0..15; `state`=3 after the 16th.
- Coefficient load of 512 words, then `frame_pulse` and 258 `word_valid` → `data_addr` wraps 255→0→1; 258 `compute_start` pulses, each one cycle after its `data_we`.
- In WORKING, `clear_req` high for 300 cycles → 256-cycle zero sweep; CLEARING held until `clear_req` drops; then `state`=5 and `data_addr`=0.
- With `MSDAP_CTRL_SLEEP_EN`: `all_zeros`=1 → `sleep`=1 next cycle. Then `word_valid` with `word_nonzero`=1 → `state`=6 and `data_we` at the held address. Without the macro: `all_zeros` has no effect.
- `start` asserted mid-READ_COEFF at coeff_addr 300 → next cycle all outputs 0 and `state`=0.

Source files
------------

// File: rtl/msdap_main_ctrl.sv
// MSDAP main sequencer: init sweep, Rj/coeff load, sample run, clear sweep, optional sleep.
// Define MSDAP_CTRL_SLEEP_EN to include the SLEEPING state and the all_zeros path.
module msdap_main_ctrl #(
    parameter int RJ_DEPTH    = 16,
    parameter int COEFF_DEPTH = 512,
    parameter int DATA_DEPTH  = 256
) (
    input  logic                           SCLK,
    input  logic                           start,
    input  logic                           frame_pulse,
    input  logic                           word_valid,
    input  logic                           word_nonzero,
    input  logic                           all_zeros,
    input  logic                           clear_req,
    output logic [3:0]                     state,
    output logic                           in_ready,
    output logic                           rj_we,
    output logic [$clog2(RJ_DEPTH)-1:0]    rj_addr,
    output logic                           coeff_we,
    output logic [$clog2(COEFF_DEPTH)-1:0] coeff_addr,
    output logic                           data_we,
    output logic [$clog2(DATA_DEPTH)-1:0]  data_addr,
    output logic                           data_zero,
    output logic                           compute_start,
    output logic                           sleep
);
    localparam int RJ_AW = $clog2(RJ_DEPTH);
    localparam int CO_AW = $clog2(COEFF_DEPTH);
    localparam int DA_AW = $clog2(DATA_DEPTH);
    localparam int MX_AW = (RJ_AW > DA_AW) ? RJ_AW : DA_AW;
    localparam int CNT_W = (CO_AW > MX_AW) ? CO_AW : MX_AW;

    typedef enum logic [3:0] {
        ST_INIT       = 4'd0,
        ST_WAIT_RJ    = 4'd1,
        ST_READ_RJ    = 4'd2,
        ST_WAIT_COEFF = 4'd3,
        ST_READ_COEFF = 4'd4,
        ST_WAIT_INPUT = 4'd5,
        ST_WORKING    = 4'd6,
        ST_CLEARING   = 4'd7,
        ST_SLEEPING   = 4'd8
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;
    logic                 r_in_ready;
    logic                 r_rj_we;
    logic [RJ_AW-1:0]     r_rj_addr;
    logic                 r_coeff_we;
    logic [CO_AW-1:0]     r_coeff_addr;
    logic                 r_data_we;
    logic [DA_AW-1:0]     r_data_addr;
    logic                 r_data_zero;
    logic                 r_compute_start;

    // Handshake: word_valid is a one-cycle pulse with the word held >=2 cycles;
    // in_ready advertises that the controller consumes it. Each accepted pulse
    // yields exactly one write strobe on the following cycle; there is no backpressure.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:       if (r_done) w_next = ST_WAIT_RJ;
            ST_WAIT_RJ:    if (frame_pulse) w_next = ST_READ_RJ;
            ST_READ_RJ:    if (word_valid && r_cnt == CNT_W'(RJ_DEPTH - 1)) w_next = ST_WAIT_COEFF;
            ST_WAIT_COEFF: if (frame_pulse) w_next = ST_READ_COEFF;
            ST_READ_COEFF: if (word_valid && r_cnt == CNT_W'(COEFF_DEPTH - 1)) w_next = ST_WAIT_INPUT;
            ST_WAIT_INPUT: if (frame_pulse) w_next = ST_WORKING;
            ST_WORKING: begin
                if (clear_req) w_next = ST_CLEARING;
`ifdef MSDAP_CTRL_SLEEP_EN
                else if (all_zeros) w_next = ST_SLEEPING;
`endif
            end
            ST_CLEARING:   if (r_done && !clear_req) w_next = ST_WAIT_INPUT;
`ifdef MSDAP_CTRL_SLEEP_EN
            ST_SLEEPING: begin
                if (clear_req) w_next = ST_CLEARING;
                else if (!all_zeros && word_valid && word_nonzero) w_next = ST_WORKING;
            end
`endif
            default:       w_next = ST_INIT;
        endcase
    end

`ifdef MSDAP_CTRL_SLEEP_EN
    logic r_sleep;
`endif

    always_ff @(posedge SCLK) begin
        if (start) begin
            r_state         <= ST_INIT;
            r_cnt           <= '0;
            r_done          <= 1'b0;
            r_in_ready      <= 1'b0;
            r_rj_we         <= 1'b0;
            r_rj_addr       <= '0;
            r_coeff_we      <= 1'b0;
            r_coeff_addr    <= '0;
            r_data_we       <= 1'b0;
            r_data_addr     <= '0;
            r_data_zero     <= 1'b0;
            r_compute_start <= 1'b0;
`ifdef MSDAP_CTRL_SLEEP_EN
            r_sleep         <= 1'b0;
`endif
        end else begin
            r_state         <= w_next;
            r_in_ready      <= !(w_next == ST_INIT || w_next == ST_CLEARING);
            r_rj_we         <= 1'b0;
            r_coeff_we      <= 1'b0;
            r_data_we       <= 1'b0;
            r_data_zero     <= 1'b0;
            r_compute_start <= r_data_we && !r_data_zero && (w_next == ST_WORKING);
`ifdef MSDAP_CTRL_SLEEP_EN
            r_sleep         <= (w_next == ST_SLEEPING);
`endif
            // data_addr points at the next free slot once the sample write retires
            if (r_data_we && !r_data_zero) r_data_addr <= r_data_addr + 1'b1;

            case (r_state)
                ST_INIT, ST_CLEARING: begin
                    if (!r_done) begin
                        r_data_we   <= 1'b1;
                        r_data_zero <= 1'b1;
                        r_data_addr <= r_cnt[DA_AW-1:0];
                        r_cnt       <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(DATA_DEPTH - 1)) r_done <= 1'b1;
                    end
                end
                ST_READ_RJ: begin
                    if (word_valid) begin
                        r_rj_we   <= 1'b1;
                        r_rj_addr <= r_cnt[RJ_AW-1:0];
                        r_cnt     <= r_cnt + 1'b1;
                    end
                end
                ST_READ_COEFF: begin
                    if (word_valid) begin
                        r_coeff_we   <= 1'b1;
                        r_coeff_addr <= r_cnt[CO_AW-1:0];
                        r_cnt        <= r_cnt + 1'b1;
                    end
                end
                ST_WORKING:  if (word_valid && w_next == ST_WORKING) r_data_we <= 1'b1;
`ifdef MSDAP_CTRL_SLEEP_EN
                ST_SLEEPING: if (w_next == ST_WORKING) r_data_we <= 1'b1;
`endif
                default: ;
            endcase

            if (w_next != r_state) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end
            if ((r_state == ST_WAIT_INPUT && w_next == ST_WORKING) ||
                (r_state == ST_CLEARING && w_next == ST_WAIT_INPUT))
                r_data_addr <= '0;
        end
    end

    assign state         = r_state;
    assign in_ready      = r_in_ready;
    assign rj_we         = r_rj_we;
    assign rj_addr       = r_rj_addr;
    assign coeff_we      = r_coeff_we;
    assign coeff_addr    = r_coeff_addr;
    assign data_we       = r_data_we;
    assign data_addr     = r_data_addr;
    assign data_zero     = r_data_zero;
    assign compute_start = r_compute_start;

`ifdef MSDAP_CTRL_SLEEP_EN
    assign sleep = r_sleep;
`else
    logic w_unused_inputs;
    assign w_unused_inputs = all_zeros ^ word_nonzero;
    assign sleep = 1'b0;
`endif
endmodule

// File: tb/tb_msdap_main_ctrl.sv
// Scoreboard bench for msdap_main_ctrl: expected write/compute events are queued by the
// drivers and popped by a monitor on every strobe; state/flag checks are done inline.
`timescale 1ns/1ps
module tb_msdap_main_ctrl;
  logic SCLK = 1'b0;
  logic start = 1'b1;
  logic frame_pulse = 1'b0;
  logic word_valid = 1'b0;
  logic word_nonzero = 1'b0;
  logic all_zeros = 1'b0;
  logic clear_req = 1'b0;
  logic [3:0] state;
  logic in_ready, rj_we, coeff_we, data_we, data_zero, compute_start, sleep;
  logic [3:0] rj_addr;
  logic [8:0] coeff_addr;
  logic [7:0] data_addr;
  logic [31:0] all_out;

  // record: {kind[1:0], zero, addr[8:0]}; kind 0=data 1=rj 2=coeff 3=compute
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic prev_dw = 1'b0;
  logic [8:0] prev_addr = '0;

  // clock/reset block
  always #5 SCLK = ~SCLK;

  msdap_main_ctrl dut (
    .SCLK(SCLK), .start(start), .frame_pulse(frame_pulse), .word_valid(word_valid),
    .word_nonzero(word_nonzero), .all_zeros(all_zeros), .clear_req(clear_req),
    .state(state), .in_ready(in_ready), .rj_we(rj_we), .rj_addr(rj_addr),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .data_we(data_we), .data_addr(data_addr),
    .data_zero(data_zero), .compute_start(compute_start), .sleep(sleep)
  );

  assign all_out = {state, in_ready, rj_we, rj_addr, coeff_we, coeff_addr, data_we,
                    data_addr, data_zero, compute_start, sleep};

  function automatic logic [11:0] rec(input logic [1:0] kind, input logic zero, input int addr);
    return {kind, zero, 9'(addr)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_check(input string nm, input logic [11:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event %0h, nothing expected", nm, act);
    end else begin
      chk(nm, 32'(act), 32'(exp_q.pop_front()));
    end
  endtask

  // monitor: pops one expected record per strobe seen
  always @(negedge SCLK) begin
    if (data_we) mon_check("data_write", {2'd0, data_zero, 1'b0, data_addr});
    if (rj_we) mon_check("rj_write", {2'd1, 1'b0, 5'd0, rj_addr});
    if (coeff_we) mon_check("coeff_write", {2'd2, 1'b0, coeff_addr});
    if (compute_start) mon_check("compute_start", {2'd3, 1'b0, (prev_dw ? prev_addr : 9'h1FF)});
    prev_dw = data_we && !data_zero;
    prev_addr = {1'b0, data_addr};
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge SCLK);
      #1;
    end
  endtask

  task automatic pulse_frame();
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic nz);
    word_valid = 1'b1;
    word_nonzero = nz;
    tick();
    word_valid = 1'b0;
    word_nonzero = 1'b0;
    tick(3);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 256; i++) exp_q.push_back(rec(2'd0, 1'b1, i));
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
    int k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(state), 32'(s));
  endtask

  task automatic load_rj();
    pulse_frame();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(rec(2'd1, 1'b0, i));
      send_word(1'b1);
    end
  endtask

  task automatic send_sample(input int addr, input logic nz);
    exp_q.push_back(rec(2'd0, 1'b0, addr));
    exp_q.push_back(rec(2'd3, 1'b0, addr));
    send_word(nz);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_outputs", all_out, 32'd0);

    push_sweep();
    start = 1'b0;
    wait_state(4'd1, 300, "init_to_wait_rj");
    chk("in_ready_wait_rj", 32'(in_ready), 32'd1);
    chk("init_sweep_done", 32'(exp_q.size()), 32'd0);

    load_rj();
    chk("rj_to_wait_coeff", 32'(state), 32'd3);

    pulse_frame();
    for (int i = 0; i < 512; i++) begin
      exp_q.push_back(rec(2'd2, 1'b0, i));
      send_word(1'b1);
    end
    chk("coeff_to_wait_input", 32'(state), 32'd5);

    pulse_frame();
    chk("enter_working", 32'(state), 32'd6);
    chk("working_addr0", 32'(data_addr), 32'd0);
    for (int i = 0; i < 258; i++) send_sample(i % 256, 1'(i % 2));
    chk("data_addr_wrapped", 32'(data_addr), 32'd2);
    chk("samples_done", 32'(exp_q.size()), 32'd0);

`ifdef MSDAP_CTRL_SLEEP_EN
    all_zeros = 1'b1;
    tick();
    all_zeros = 1'b0;
    chk("sleep_flag", 32'(sleep), 32'd1);
    chk("sleep_state", 32'(state), 32'd8);
    chk("sleep_in_ready", 32'(in_ready), 32'd1);
    send_word(1'b0);
    chk("sleep_zero_word", 32'(state), 32'd8);
    send_sample(2, 1'b1);
    chk("wake_state", 32'(state), 32'd6);
    chk("wake_sleep_low", 32'(sleep), 32'd0);
`else
    all_zeros = 1'b1;
    tick(2);
    chk("all_zeros_ignored", 32'(state), 32'd6);
    chk("sleep_tied_low", 32'(sleep), 32'd0);
    send_sample(2, 1'b0);
    all_zeros = 1'b0;
    chk("still_working", 32'(state), 32'd6);
`endif

    push_sweep();
    clear_req = 1'b1;
    word_valid = 1'b1;
    word_nonzero = 1'b1;
    tick();
    word_valid = 1'b0;
    word_nonzero = 1'b0;
    chk("enter_clearing", 32'(state), 32'd7);
    chk("clearing_in_ready", 32'(in_ready), 32'd0);
    tick(298);
    chk("clearing_held", 32'(state), 32'd7);
    chk("clear_sweep_done", 32'(exp_q.size()), 32'd0);
    clear_req = 1'b0;
    wait_state(4'd5, 10, "clear_exit");
    chk("clear_exit_addr", 32'(data_addr), 32'd0);
    chk("clear_exit_in_ready", 32'(in_ready), 32'd1);
    clear_req = 1'b1;
    tick(2);
    clear_req = 1'b0;
    chk("clear_ignored_wait_input", 32'(state), 32'd5);

    pulse_frame();
    send_sample(0, 1'b1);
    chk("post_clear_addr", 32'(data_addr), 32'd1);

    start = 1'b1;
    tick();
    chk("abort_working_outputs", all_out, 32'd0);
    push_sweep();
    start = 1'b0;
    wait_state(4'd1, 300, "reinit");
    load_rj();
    pulse_frame();
    for (int i = 0; i < 301; i++) begin
      if (i == 100) clear_req = 1'b1;
      if (i == 110) clear_req = 1'b0;
      exp_q.push_back(rec(2'd2, 1'b0, i));
      send_word(1'b1);
    end
    chk("clear_ignored_coeff", 32'(state), 32'd4);
    chk("coeff_addr_300", 32'(coeff_addr), 32'd300);
    start = 1'b1;
    tick();
    chk("abort_coeff_outputs", all_out, 32'd0);
    push_sweep();
    start = 1'b0;
    wait_state(4'd1, 300, "reinit_after_abort");
    tick(3);
    chk("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
